// File: rtl/memory.sv
// rtl/memory.sv - single-port synchronous RAM with registered read data and ready; optional MEMORY_CLEAR_EN clears mem on reset
module memory #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_rd,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  input  logic                  valid,
  output logic                  ready
);

  // Storage kept as one flat array so hierarchical backdoor access lands on it directly.
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // A write only happens when the request is sampled outside reset.
  logic do_write;
  logic do_read;

  // Decode the sampled request; reset masks both operations so an in-flight write is aborted.
  always_comb begin
    do_write = 1'b0;
    do_read  = 1'b0;
    if (!res && valid) begin
      do_write = wr_rd;
      do_read  = !wr_rd;
    end
  end

`ifdef MEMORY_CLEAR_EN
  // Array update: reset wipes every location asynchronously, otherwise accept the write.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[addr] <= wdata;
    end
  end
`else
  // Array update: reset leaves contents alone, a write sampled while res is high is dropped.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[addr] <= wdata;
    end
  end
`endif

  // Registered read data; holds across writes and idle cycles, forced to 0 by reset.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rdata <= '0;
    end else if (do_read) begin
      rdata <= mem[addr];
    end
  end

  // ready reflects whether the previous edge sampled a request; every request completes in one cycle.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ready <= 1'b0;
    end else begin
      ready <= valid;
    end
  end

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - randomized self-checking bench for memory against an array reference model
module tb_memory;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             res;
  logic [AW-1:0]    addr;
  logic             wr_rd;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             valid;
  logic             ready;

  int errors;
  int checks;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] ref_rdata;
  logic             ref_ready;

  memory #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .res   (res),
    .addr  (addr),
    .wr_rd (wr_rd),
    .wdata (wdata),
    .rdata (rdata),
    .valid (valid),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request (or idle) for a single cycle, update the model, then check outputs.
  task automatic do_cycle(input string tag, input logic v, input logic w,
                          input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    valid = v;
    wr_rd = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    ref_ready = v;
    if (v && !w) ref_rdata = ref_mem[a];
    if (v && w)  ref_mem[a] = d;
    check_eq({tag, "_ready"}, {31'd0, ready}, {31'd0, ref_ready});
    check_eq({tag, "_rdata"}, {24'd0, rdata}, {24'd0, ref_rdata});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    res    = 1'b0;
    valid  = 1'b0;
    wr_rd  = 1'b0;
    addr   = '0;
    wdata  = '0;
    ref_rdata = '0;
    ref_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state, checked while reset is asserted
    #2 res = 1'b1;
    #1;
    check_eq("reset_ready", {31'd0, ready}, 32'd0);
    check_eq("reset_rdata", {24'd0, rdata}, 32'd0);
    #19 res = 1'b0;

    // Fill every address with random data, then read it all back
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle("fill", 1'b1, 1'b1, AW'(i), WIDTH'($urandom));
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle("readback", 1'b1, 1'b0, AW'(i), WIDTH'($urandom));
    end

    // Read-after-write then idle: rdata must hold, ready must drop
    do_cycle("raw_wr", 1'b1, 1'b1, AW'(7), 8'h3C);
    do_cycle("raw_rd", 1'b1, 1'b0, AW'(7), 8'h00);
    check_eq("raw_value", {24'd0, rdata}, 32'h3C);
    for (int i = 0; i < 3; i++) begin
      do_cycle("idle", 1'b0, 1'($urandom), AW'($urandom), WIDTH'($urandom));
    end

    // Random mixed traffic, including idle cycles and address reuse
    for (int i = 0; i < 300; i++) begin
      do_cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom),
               AW'($urandom), WIDTH'($urandom));
    end

    // Make rdata nonzero so the asynchronous clear is observable
    do_cycle("pre_rst_wr", 1'b1, 1'b1, AW'(3), 8'hA5);
    do_cycle("pre_rst_rd", 1'b1, 1'b0, AW'(3), 8'h00);
    do_cycle("pre_rst_wr2", 1'b1, 1'b1, AW'(3), 8'hA5);

    // Reset asserted during the next write to address 3
    valid = 1'b1;
    wr_rd = 1'b1;
    addr  = AW'(3);
    wdata = 8'h5A;
    #2 res = 1'b1;
    #1;
    check_eq("midrst_ready", {31'd0, ready}, 32'd0);
    check_eq("midrst_rdata", {24'd0, rdata}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("midrst_hold_ready", {31'd0, ready}, 32'd0);
    check_eq("midrst_hold_rdata", {24'd0, rdata}, 32'd0);
    valid = 1'b0;
    res   = 1'b0;
    ref_ready = 1'b0;
    ref_rdata = '0;
`ifdef MEMORY_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    do_cycle("post_rst_rd3", 1'b1, 1'b0, AW'(3), 8'h00);
`ifdef MEMORY_CLEAR_EN
    check_eq("post_rst_addr3", {24'd0, rdata}, 32'h00);
`else
    check_eq("post_rst_addr3", {24'd0, rdata}, 32'hA5);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle("post_rst_scan", 1'b1, 1'b0, AW'(i), 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
